// File: rtl/exp_accel_param.sv
// ============================================================================
// Module      : exp_accel_param
// Description : Sequential e^x / e^-x accelerator for an unsigned fraction x
//               in [0,1), using a truncated Taylor series. One shared
//               multiplier alternates between the x multiply and the
//               reciprocal-ROM multiply; a controller FSM applies each
//               term to an accumulator. The result is held until the next
//               completion or reset.
// Ports       : clk        - clock, rising edge
//               rst        - synchronous active-high reset
//               start      - request, sampled only while idle
//               x          - operand, value x/2^FW
//               neg        - 0: e^x, 1: e^-x
//               busy       - high in every non-idle state
//               done       - one-cycle pulse when the result updates
//               intpart    - integer part of the held result
//               fracpart   - fraction part of the held result
//               terms_used - terms in the held result, including the 1
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exp_accel_param #(
  parameter int FW         = 16,
  parameter int IW         = 2,
  parameter int NTERMS     = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [FW-1:0] x,
  input  logic          neg,
  output logic          busy,
  output logic          done,
  output logic [IW-1:0] intpart,
  output logic [FW-1:0] fracpart,
  output logic [3:0]    terms_used
);

  localparam int AW = IW + FW;       // accumulator width
  localparam int PW = 2 * FW + 2;    // shared product width

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_MULX = 3'd2,
    S_MULR = 3'd3,
    S_ACC  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [AW-1:0] c_ACC_ONE = AW'(1) << FW;
  localparam logic [FW:0]   c_T_ONE   = {1'b1, {FW{1'b0}}};

  state_t          r_state;
  logic [AW-1:0]   r_acc;
  logic [FW:0]     r_t;
  logic [4:0]      r_i;
  logic [FW-1:0]   r_xr;
  logic            r_nr;
  logic            r_busy;
  logic            r_done;
  logic [IW-1:0]   r_int;
  logic [FW-1:0]   r_frac;
  logic [3:0]      r_terms;

  // Reciprocal ROM: entry i holds floor(2^FW / i). Sized to the full 5-bit
  // index range so the counter can address it directly; unused slots are 0.
  logic [FW:0] w_recip [0:31];

  for (genvar g = 0; g < 32; g++) begin : g_rom
    if (g >= 1 && g < NTERMS) begin : g_ent
      assign w_recip[g] = (FW+1)'((64'd1 << FW) / 64'(g));
    end else begin : g_zero
      assign w_recip[g] = '0;
    end
  end

  // Shared multiplier: t*x in MULX, t*recip[i] otherwise. Both results are
  // bounded by t, so the FW+1 bits above the binary point hold them exactly.
  logic [FW:0]   w_mul_b;
  logic [PW-1:0] w_prod;
  logic [FW:0]   w_t_next;
  logic [FW:0]   w_unused_prod;

  assign w_mul_b       = (r_state == S_MULX) ? {1'b0, r_xr} : w_recip[r_i];
  assign w_prod        = PW'(r_t) * PW'(w_mul_b);
  assign w_t_next      = w_prod[2*FW:FW];
  assign w_unused_prod = {w_prod[PW-1], w_prod[FW-1:0]};

  // Term application with saturation above and clamping below.
  logic [AW-1:0] w_t_ext;
  logic [AW:0]   w_sum;
  logic          w_sub;
  logic [AW-1:0] w_acc_next;
  logic [4:0]    w_i_inc;

  assign w_t_ext = AW'(r_t);
  assign w_sum   = (AW+1)'(r_acc) + (AW+1)'(w_t_ext);
  assign w_sub   = r_nr & r_i[0];     // odd powers are negative for e^-x
  assign w_i_inc = r_i + 5'd1;

  always_comb begin
    w_acc_next = w_sum[AW-1:0];
    if (w_sub) begin
      if (w_t_ext > r_acc) begin
        w_acc_next = '0;
      end else begin
        w_acc_next = r_acc - w_t_ext;
      end
    end else if (w_sum[AW]) begin
      w_acc_next = '1;
    end
  end

  // The result registers and done are loaded on the edge that enters DONE,
  // so they are visible during the DONE cycle itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_t     <= '0;
      r_i     <= '0;
      r_xr    <= '0;
      r_nr    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_int   <= '0;
      r_frac  <= '0;
      r_terms <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_LOAD;
            r_busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          r_xr    <= x;
          r_nr    <= neg;
          r_acc   <= c_ACC_ONE;
          r_t     <= c_T_ONE;
          r_i     <= 5'd1;
          r_state <= S_MULX;
        end
        S_MULX: begin
          r_t     <= w_t_next;
          r_state <= S_MULR;
        end
        S_MULR: begin
          r_t <= w_t_next;
          if ((EARLY_EXIT != 0) && (w_t_next == '0)) begin
            // Term i is zero and not applied: i-1 terms plus the constant.
            {r_int, r_frac} <= r_acc;
            r_terms         <= r_i[3:0];
            r_done          <= 1'b1;
            r_state         <= S_DONE;
          end else begin
            r_state <= S_ACC;
          end
        end
        S_ACC: begin
          r_acc <= w_acc_next;
          r_i   <= w_i_inc;
          if (w_i_inc == 5'(NTERMS)) begin
            {r_int, r_frac} <= w_acc_next;
            r_terms         <= w_i_inc[3:0];
            r_done          <= 1'b1;
            r_state         <= S_DONE;
          end else begin
            r_state <= S_MULX;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign intpart    = r_int;
  assign fracpart   = r_frac;
  assign terms_used = r_terms;

endmodule

`default_nettype wire

// File: tb/tb_exp_accel_param.sv
// ============================================================================
// Module      : tb_exp_accel_param
// Description : Scoreboard bench for exp_accel_param. Each accepted request
//               pushes the reference result (series evaluated with plain
//               integer arithmetic) and its completion cycle; a monitor pops
//               and compares whenever done is seen.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exp_accel_param;

  localparam int FW     = 16;
  localparam int IW     = 2;
  localparam int NTERMS = 8;
  localparam int EARLY  = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [FW-1:0] x = '0;
  logic          neg = 1'b0;
  logic          busy;
  logic          done;
  logic [IW-1:0] intpart;
  logic [FW-1:0] fracpart;
  logic [3:0]    terms_used;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    longint res;
    int     tu;
    int     dcyc;
  } exp_t;

  exp_t sb[$];

  exp_accel_param #(
    .FW(FW), .IW(IW), .NTERMS(NTERMS), .EARLY_EXIT(EARLY)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .neg(neg),
    .busy(busy), .done(done), .intpart(intpart), .fracpart(fracpart),
    .terms_used(terms_used)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic near(input string name, input longint act, input longint req, input longint tol);
    longint d;
    d = (act > req) ? act - req : req - act;
    checks++;
    if (d > tol) begin
      errors++;
      $display("FAIL %s actual %0h required %0h +/- %0d", name, act, req, tol);
    end
  endtask

  // Reference: sum of x^j/j! with each term truncated after the x multiply
  // and after the reciprocal multiply; alternating signs for e^-x.
  function automatic exp_t model(input longint xv, input bit nv, input int e_cyc);
    exp_t   e;
    longint one, t, acc, maxv;
    int     lat;
    one  = 64'd1 << FW;
    maxv = (64'd1 << (IW + FW)) - 1;
    t    = one;
    acc  = one;
    e.tu = NTERMS;
    lat  = 3 * (NTERMS - 1) + 1;
    for (int j = 1; j < NTERMS; j++) begin
      t = (t * xv) >> FW;
      t = (t * (one / j)) >> FW;
      if (EARLY != 0 && t == 0) begin
        e.tu = j;
        lat  = 3 * j;
        break;
      end
      if (nv && (j % 2 == 1)) acc = acc - t;
      else                    acc = acc + t;
      if (acc < 0)    acc = 0;
      if (acc > maxv) acc = maxv;
    end
    e.res  = acc;
    e.dcyc = e_cyc + lat;
    return e;
  endfunction

  // Monitor: every done pulse must correspond to a queued expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual 1 required 0 at cyc %0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", {intpart, fracpart}, e.res);
        check("terms_used", terms_used, e.tu);
        check("done_cycle", cyc, e.dcyc);
        check("busy_in_done", busy, 1);
      end
    end
  end

  // Drive start at a negedge; the next rising edge samples it.
  task automatic push_req(input logic [FW-1:0] xv, input bit nv);
    start = 1'b1;
    x     = xv;
    neg   = nv;
    sb.push_back(model(longint'(xv), nv, cyc + 1));
  endtask

  task automatic wait_idle(input bit noise);
    int guard = 0;
    while (busy && guard < 200) begin
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        x     = FW'($urandom);
        neg   = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    if (guard >= 200) check("idle_timeout", 1, 0);
  endtask

  task automatic issue(input logic [FW-1:0] xv, input bit nv, input bit noise);
    @(negedge clk);
    wait_idle(1'b0);
    push_req(xv, nv);
    @(negedge clk);   // LOAD
    start = 1'b0;
    @(negedge clk);   // operands captured
    wait_idle(noise);
  endtask

  initial begin
    int guard;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_int", intpart, 0);
    check("rst_frac", fracpart, 0);
    check("rst_terms", terms_used, 0);

    // Zero operand, both signs: first term already zero.
    issue(16'h0000, 1'b0, 1'b0);
    check("zero_int", intpart, 1);
    check("zero_frac", fracpart, 0);
    check("zero_terms", terms_used, 1);
    issue(16'h0000, 1'b1, 1'b0);
    check("zero_neg_int", intpart, 1);
    check("zero_neg_frac", fracpart, 0);

    // Half operand against the analytic values.
    issue(16'h8000, 1'b0, 1'b0);
    near("exp_half", {intpart, fracpart}, 64'h1A612, 8);
    issue(16'h8000, 1'b1, 1'b0);
    check("expn_half_int", intpart, 0);
    near("expn_half", {intpart, fracpart}, 64'h9B45, 8);

    // Largest operand.
    issue(16'hFFFF, 1'b0, 1'b0);
    check("max_int", intpart, 2);
    near("max_frac", fracpart, 64'hB7E0, 8);

    // Spurious starts and operand changes during the run and in DONE.
    issue(16'hC000, 1'b1, 1'b1);
    issue(16'h3333, 1'b0, 1'b1);

    // Reset in the middle of a run.
    @(negedge clk);
    push_req(16'h8000, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_int", intpart, 0);
    check("midrst_frac", fracpart, 0);
    check("midrst_terms", terms_used, 0);
    repeat (30) @(negedge clk);   // any stray done would hit an empty queue
    issue(16'h8000, 1'b0, 1'b0);

    // Start held through DONE (ignored) and into the following idle cycle.
    @(negedge clk);
    push_req(16'h2000, 1'b1);
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!done && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("b2b_timeout", 1, 0);
    start = 1'b1;
    x     = 16'h7000;
    neg   = 1'b0;
    @(negedge clk);
    check("b2b_idle_busy", busy, 0);
    sb.push_back(model(64'h7000, 1'b0, cyc + 1));
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    wait_idle(1'b0);

    // Randomized operands, some with noise during the run.
    for (int n = 0; n < 25; n++) begin
      issue(FW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    check("queue_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
